// File: rtl/alu_reg_if.sv
// Operand/result bundle for alu_reg. The datapath side drives operands and the
// ALU side returns the registered result and flags.
interface alu_reg_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [5:0]       ALUFun;
    logic             Sign;
    logic [WIDTH-1:0] Z;
    logic             Zero;
    logic             V;
    logic             N;

    modport master (
        output A, B, ALUFun, Sign,
        input  Z, Zero, V, N
    );

    modport slave (
        input  A, B, ALUFun, Sign,
        output Z, Zero, V, N
    );
endinterface

// File: rtl/alu_reg.sv
// 32-bit MIPS-style ALU with registered result and flags: one shared adder feeds
// the flags for every function; ALUFun[5:4] picks arithmetic, logic, shift or compare.
module alu_reg #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    alu_reg_if.slave   bus
);

    logic [WIDTH:0]   sumExt;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             isSub;
    logic             aMsb;
    logic             bMsb;
    logic [4:0]       shamt;

    logic [WIDTH-1:0] z_d, z_q;
    logic             zero_d, zero_q;
    logic             v_d, v_q;
    logic             n_d, n_q;
    logic             cmp;

    assign isSub  = bus.ALUFun[0];
    assign sumExt = isSub ? ({1'b0, bus.A} - {1'b0, bus.B})
                          : ({1'b0, bus.A} + {1'b0, bus.B});
    assign sum    = sumExt[WIDTH-1:0];
    // On subtraction the 33rd bit is the borrow (set exactly when A < B unsigned).
    assign carry  = sumExt[WIDTH];
    assign aMsb   = bus.A[WIDTH-1];
    assign bMsb   = bus.B[WIDTH-1];
    assign shamt  = bus.A[4:0];

    always_comb begin
        zero_d = (sum == '0);
        if (bus.Sign) begin
            if (isSub) v_d = (aMsb != bMsb) && (sum[WIDTH-1] != aMsb);
            else       v_d = (aMsb == bMsb) && (sum[WIDTH-1] != aMsb);
            n_d = sum[WIDTH-1] ^ v_d;
        end else begin
            v_d = carry;
            n_d = isSub & carry;
        end
    end

    // Compare results use exact comparators so overflowing operands still order correctly.
    always_comb begin
        cmp = 1'b0;
        unique case (bus.ALUFun[3:1])
            3'b001:  cmp = (bus.A == bus.B);
            3'b000:  cmp = (bus.A != bus.B);
            3'b010:  cmp = bus.Sign ? ($signed(bus.A) < $signed(bus.B)) : (bus.A < bus.B);
            3'b110:  cmp = aMsb || (bus.A == '0);
            3'b100,
            3'b101:  cmp = aMsb;
            3'b111:  cmp = !aMsb && (bus.A != '0);
            default: cmp = 1'b0;
        endcase
    end

    always_comb begin
        z_d = '0;
        unique case (bus.ALUFun[5:4])
            2'b00: z_d = sum;
            2'b01: begin
                unique case (bus.ALUFun[3:0])
                    4'b1000: z_d = bus.A & bus.B;
                    4'b1110: z_d = bus.A | bus.B;
                    4'b0110: z_d = bus.A ^ bus.B;
                    4'b0001: z_d = ~(bus.A | bus.B);
                    4'b1010: z_d = bus.A;
                    default: z_d = '0;
                endcase
            end
            2'b10: begin
                unique case (bus.ALUFun[1:0])
                    2'b00:   z_d = bus.B << shamt;
                    2'b01:   z_d = bus.B >> shamt;
                    2'b11:   z_d = $signed(bus.B) >>> shamt;
                    default: z_d = '0;
                endcase
            end
            default: z_d = {{(WIDTH-1){1'b0}}, cmp};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            z_q    <= '0;
            zero_q <= 1'b0;
            v_q    <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            z_q    <= z_d;
            zero_q <= zero_d;
            v_q    <= v_d;
            n_q    <= n_d;
        end
    end

    assign bus.Z    = z_q;
    assign bus.Zero = zero_q;
    assign bus.V    = v_q;
    assign bus.N    = n_q;

endmodule

// File: tb/tb_alu_reg.sv
// Bench for alu_reg: directed corner cases plus random traffic, each result
// compared against a wide-integer reference model of the ALU rules.
module tb_alu_reg;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    alu_reg_if #(.WIDTH(32)) bus ();

    alu_reg #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference: exact math in 64-bit integers, flags read off the true result.
    function automatic logic [34:0] refModel(input logic [31:0] a, input logic [31:0] b,
                                             input logic [5:0] f, input logic s);
        longint sa, sb, ua, ub, math;
        logic [31:0] r, wrapped;
        logic v, n, zf, c;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (s) begin
            math = f[0] ? sa - sb : sa + sb;
            v = (math > 64'sd2147483647) || (math < -64'sd2147483648);
        end else begin
            math = f[0] ? ua - ub : ua + ub;
            v = (math < 0) || (math > 64'sd4294967295);
        end
        n = (math < 0);
        wrapped = math[31:0];
        zf = (wrapped == 32'd0);
        r = 32'd0;
        case (f[5:4])
            2'b00: r = wrapped;
            2'b01: case (f[3:0])
                4'b1000: r = a & b;
                4'b1110: r = a | b;
                4'b0110: r = a ^ b;
                4'b0001: r = ~(a | b);
                4'b1010: r = a;
                default: r = 32'd0;
            endcase
            2'b10: case (f[1:0])
                2'b00:   r = b << a[4:0];
                2'b01:   r = b >> a[4:0];
                2'b11:   r = 32'(sb >>> a[4:0]);
                default: r = 32'd0;
            endcase
            default: begin
                case (f[3:1])
                    3'b001:  c = (a == b);
                    3'b000:  c = (a != b);
                    3'b010:  c = s ? (sa < sb) : (ua < ub);
                    3'b110:  c = (sa <= 0);
                    3'b100,
                    3'b101:  c = (sa < 0);
                    3'b111:  c = (sa > 0);
                    default: c = 1'b0;
                endcase
                r = {31'd0, c};
            end
        endcase
        return {n, v, zf, r};
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [5:0] f, input logic s);
        logic [34:0] exp;
        bus.A = a;
        bus.B = b;
        bus.ALUFun = f;
        bus.Sign = s;
        exp = refModel(a, b, f, s);
        @(posedge clk);
        #1;
        checkOutput("Z",    bus.Z,           exp[31:0]);
        checkOutput("Zero", {31'd0, bus.Zero}, {31'd0, exp[32]});
        checkOutput("V",    {31'd0, bus.V},    {31'd0, exp[33]});
        checkOutput("N",    {31'd0, bus.N},    {31'd0, exp[34]});
    endtask

    task automatic checkReset();
        checkOutput("rstZ",    bus.Z,             32'd0);
        checkOutput("rstZero", {31'd0, bus.Zero}, 32'd0);
        checkOutput("rstV",    {31'd0, bus.V},    32'd0);
        checkOutput("rstN",    {31'd0, bus.N},    32'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] edges [5] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
        case ($urandom_range(0, 3))
            0:       return edges[$urandom_range(0, 4)];
            1:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic        s;
        logic [31:0] z;
    } vec_t;

    vec_t vecs [] = '{
        '{32'h7FFFFFFF, 32'h70000000, 6'b000000, 1'b1, 32'hEFFFFFFF},
        '{32'hFFFFFFFF, 32'h00000001, 6'b000000, 1'b0, 32'h00000000},
        '{32'h80000001, 32'h0000000F, 6'b000001, 1'b1, 32'h7FFFFFF2},
        '{32'h00000005, 32'h00000005, 6'b000001, 1'b1, 32'h00000000},
        '{32'h00000005, 32'h00000063, 6'b011000, 1'b1, 32'h00000001},
        '{32'h00000005, 32'h00000063, 6'b011110, 1'b1, 32'h00000067},
        '{32'h00000005, 32'h00000063, 6'b010110, 1'b1, 32'h00000066},
        '{32'h00000005, 32'h00000063, 6'b010001, 1'b1, 32'hFFFFFF98},
        '{32'h00000005, 32'h00000063, 6'b011010, 1'b1, 32'h00000005},
        '{32'h00000005, 32'h00000063, 6'b011111, 1'b1, 32'h00000000},
        '{32'h0000000A, 32'hFFFFF020, 6'b100000, 1'b1, 32'hFFC08000},
        '{32'h0000000A, 32'hFFFFF020, 6'b100001, 1'b1, 32'h003FFFFC},
        '{32'h0000000A, 32'hFFFFF020, 6'b100011, 1'b1, 32'hFFFFFFFC},
        '{32'h00000000, 32'hFFFFF020, 6'b100011, 1'b1, 32'hFFFFF020},
        '{32'h0000000A, 32'hFFFFF020, 6'b100010, 1'b1, 32'h00000000},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b110011, 1'b1, 32'h00000000},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b110001, 1'b1, 32'h00000001},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b110101, 1'b1, 32'h00000001},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b110101, 1'b0, 32'h00000000},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b111101, 1'b1, 32'h00000001},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b111001, 1'b1, 32'h00000001},
        '{32'hFFFFFFF9, 32'h0000000A, 6'b111111, 1'b1, 32'h00000000},
        '{32'h00000000, 32'h0000000A, 6'b111101, 1'b1, 32'h00000001},
        '{32'h00000000, 32'h0000000A, 6'b111001, 1'b1, 32'h00000000},
        '{32'h00000000, 32'h0000000A, 6'b111111, 1'b1, 32'h00000000},
        '{32'h80000000, 32'h00000001, 6'b110101, 1'b1, 32'h00000001},
        '{32'h80000000, 32'h00000001, 6'b110101, 1'b0, 32'h00000000}
    };

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.A = $urandom;
        bus.B = $urandom;
        bus.ALUFun = 6'b000000;
        bus.Sign = 1'b1;

        // Reset must hold outputs at zero even with live operands on the bus.
        repeat (2) @(posedge clk);
        #1;
        checkReset();
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].s);
            checkOutput("dirZ", bus.Z, vecs[i].z);
        end

        // Flag corners called out by the overflow cases.
        applyStimulus(32'h7FFFFFFF, 32'h70000000, 6'b000000, 1'b1);
        checkOutput("addV", {31'd0, bus.V}, 32'd1);
        applyStimulus(32'hFFFFFFFF, 32'h00000001, 6'b000000, 1'b0);
        checkOutput("uaddZero", {31'd0, bus.Zero}, 32'd1);
        applyStimulus(32'h80000001, 32'h0000000F, 6'b000001, 1'b1);
        checkOutput("subN", {31'd0, bus.N}, 32'd1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(pickOperand(), pickOperand(), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        // Mid-stream reset overrides whatever is being computed.
        bus.A = 32'h7FFFFFFF;
        bus.B = 32'h70000000;
        bus.ALUFun = 6'b000000;
        bus.Sign = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkReset();
        reset = 1'b0;
        applyStimulus(32'h7FFFFFFF, 32'h70000000, 6'b000000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_reg.md
Name: alu_reg

Overview:
- 32-bit integer ALU for the MIPS-style CPU datapath.
- The 6-bit function code ALUFun selects one of four groups: add/sub, bitwise logic, shift, or compare.
- Sign selects signed or unsigned interpretation.
- Z and the flags Zero, V, N are registered; all outputs appear one clock after the inputs are sampled.

Parameters:
- WIDTH, 32, data width. Behaviour is defined for 32 only; shift amount is A[4:0].

Ports:
- clk    input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A      input  32 operand A; also the shift amount (A[4:0]) for shifts.
- B      input  32 operand B; the value shifted for shifts.
- ALUFun input  6  function select.
- Sign   input  1  1 = signed, 0 = unsigned.
- Z      output 32 registered result.
- Zero   output 1  registered: adder result equals 0.
- V      output 1  registered: overflow.
- N      output 1  registered: adder result is mathematically negative.

Behaviour:
- Reset: a rising clk with reset=1 sets Z=0, Zero=0, V=0, N=0. Reset overrides any operation in progress.
- Latency: combinational compute, registered every cycle with no enable. Inputs sampled at edge k appear on outputs after edge k; no handshake.
- Group select ALUFun[5:4]: 00 arithmetic, 01 logic, 10 shift, 11 compare.
- Adder (shared by all groups): S = A+B when ALUFun[0]=0, S = A-B when ALUFun[0]=1, modulo 2^32.
- Flags are computed from S for every ALUFun value:
  - Zero = (S==0).
  - Sign=1, V: add: A[31]==B[31] and S[31]!=A[31]; sub: A[31]!=B[31] and S[31]!=A[31].
  - Sign=1, N = S[31] XOR V (true sign).
  - Sign=0, V: add: carry-out; sub: borrow (A<B unsigned).
  - Sign=0, N: 0 for add; equals the borrow for sub.
- Arithmetic group: Z = S. The 0x/1x codes beyond bit 0 are don't-care.
- Logic group, by ALUFun[3:0]:
  - 1000 A AND B
  - 1110 A OR B
  - 0110 A XOR B
  - 0001 NOR(A,B)
  - 1010 A (pass)
  - any other code gives Z=0.
- Shift group, by ALUFun[1:0], with shamt = A[4:0]:
  - 00 B<<shamt
  - 01 B>>shamt logical
  - 11 B>>>shamt arithmetic
  - 10 gives Z=0.
  - shamt=0 passes B unchanged.
- Compare group: Z = {31'b0, c}, with c selected by ALUFun[3:1]:
  - 001 EQ: A==B
  - 000 NEQ: A!=B
  - 010 LT: A<B, signed if Sign=1, else unsigned.
  - 110 LEZ: A<=0
  - 100 and 101 LTZ: A<0
  - 111 GTZ: A>0
  - 011 gives c=0.
  - LEZ, LTZ and GTZ always treat A as signed two's complement, independent of Sign.
- EQ/NEQ/LT are exact comparisons, not derived from a wrapped S; they must hold at overflow boundaries (e.g. 0x80000000 vs 0x00000001).
- X/undriven ALUFun: no requirement; the bench drives all inputs before reset deassertion.

Test Plan:
- Reset: assert reset for 2 cycles with arbitrary inputs -> Z=0, Zero=V=N=0. Release -> the next cycle shows the computed result.
- Add overflow: Sign=1, ALUFun=000000, A=0x7FFFFFFF, B=0x70000000 -> Z=0xEFFFFFFF, V=1, N=0, Zero=0. Sign=0, A=0xFFFFFFFF, B=1 -> Z=0, Zero=1, V=1.
- Sub: Sign=1, ALUFun=000001, A=0x80000001, B=0x0000000F -> Z=0x7FFFFFF2, V=1, N=1. A=B=5 -> Zero=1, N=0.
- Logic, A=5, B=0x63:
  - 011000 -> 0x00000001
  - 011110 -> 0x00000067
  - 010110 -> 0x00000066
  - 010001 -> 0xFFFFFF98
  - 011010 -> 0x00000005
  - 011111 -> 0
- Shift, A=10, B=0xFFFFF020:
  - 100000 -> 0xFFC08000
  - 100001 -> 0x003FFFFC
  - 100011 -> 0xFFFFFFFC
  - A=0 with 100011 -> 0xFFFFF020
- Compare, A=0xFFFFFFF9, B=10, Sign=1:
  - 110011 -> 0
  - 110001 -> 1
  - 110101 -> 1 (Sign=0 -> 0)
  - 111101 -> 1
  - 111001 -> 1
  - 111111 -> 0
  - A=0: LEZ -> 1, LTZ -> 0, GTZ -> 0
  - A=0x80000000, B=1, LT signed -> 1
